otn_frame_rx: RTL and testbench
===============================

# otn_frame_rx

Receive end of the serial OTN frame link. Recovers bit timing from the single-wire serial line using the shared 16x baud enable, hunts for the OTN frame alignment signal (FAS), and deserializes each frame into bytes for the demapper. At end of frame it checks an XOR checksum and, when ARQ is enabled, returns a one-bit good/bad ACK on the return line consumed by the frame sender.

## Interface
- FRAME_BYTES, 4165: total bytes per frame, including 6 FAS bytes and the final checksum byte; minimum 8.
- FAS_PATTERN, 48'hF6F6F6282828: FAS bytes; the first transmitted byte is bits [47:40].
- i_clk  in  1  system clock.
- i_rst  in  1  reset; synchronous, active-high; clock i_clk.
- i_sclk_en_16_x_baud  in  1  one-cycle enable at 16x baud rate.
- i_otn_rx_data  in  1  serial frame line, asynchronous, bytes LSB first, no per-byte framing.
- i_arq_en  in  1  ACK return enable (switch), sampled in CHECK.
- o_frame_data  out  8  received payload or checksum byte.
- o_frame_data_valid  out  1  one-cycle strobe per byte on o_frame_data.
- o_frame_data_fas  out  1  one-cycle pulse on FAS lock.
- o_frame_good  out  1  one-cycle pulse: frame checksum matched.
- o_frame_bad  out  1  one-cycle pulse: checksum mismatch.
- o_otn_tx_ack  out  1  ACK return line; idles high.

## Operation
- Input passes through a 2-flop synchronizer; all logic uses the synchronized bit (rx_s).
- Bit recovery: 4-bit phase counter increments on each i_sclk_en_16_x_baud. Any rx_s edge resets it to 0. Sample rx_s on the enable where phase == 7. Phase counter wraps 15->0.
- State machine (3-bit): HUNT, RECEIVE, CHECK, ACK_START, ACK_BIT, ACK_STOP.
- HUNT: each sampled bit shifts into a 48-bit register, with the newest bit entering the MSB side of the current byte and LSB-first byte order rebuilt. When the register equals FAS_PATTERN: pulse o_frame_data_fas, set byte index = 6, clear bit count and checksum, go to RECEIVE.
- RECEIVE: assemble 8 samples LSB first. On the 8th bit, present the byte with o_frame_data_valid. XOR every byte with index 6..FRAME_BYTES-2 into the 8-bit checksum. Byte index FRAME_BYTES-1 is the checksum byte; after presenting it, go to CHECK.
- CHECK (1 cycle): ack = (checksum byte == accumulated XOR). Pulse o_frame_good if ack, else o_frame_bad. If i_arq_en, go to ACK_START; otherwise go to HUNT.
- ACK_START: o_otn_tx_ack=0. ACK_BIT: o_otn_tx_ack=ack. ACK_STOP: o_otn_tx_ack=0. Each state lasts exactly one i_clk cycle, then go to HUNT with o_otn_tx_ack=1. This is the sender's one-clock ACK sampling format.
- Entering HUNT clears the 48-bit shift register, so a retransmitted frame is re-acquired from its FAS.
- Byte index: 13-bit counter, never exceeds FRAME_BYTES-1.
- Line edges seen outside HUNT/RECEIVE still resync the phase but generate no data.

## Timing
- Reset values: o_frame_data=0, o_frame_data_valid=0, o_frame_data_fas=0, o_frame_good=0, o_frame_bad=0, o_otn_tx_ack=1. State goes to HUNT; all counters and the checksum are 0.
- Sampling point: the 8th 16x enable after the last edge, i.e. about mid-bit.
- o_frame_data_valid and o_frame_data_fas assert on the cycle after the sampling enable of the completing bit, registered.
- CHECK is entered the cycle after the final byte's valid strobe. o_frame_good/o_frame_bad are registered outputs of CHECK, asserted the cycle after CHECK. ACK_START is driven on the line in the same cycle. The ACK sequence spans 3 cycles, after which the line returns high.
- No backpressure: downstream must accept every valid strobe.
- Reset mid-frame or mid-ACK aborts immediately: no good/bad pulse, line high the next cycle.
- i_arq_en changes are honoured only at CHECK.

## Configuration
- OTN_RX_CHECKSUM_EN defined: behaviour as above.
- Undefined: no checksum accumulator. The final byte is still presented, ack is forced to 1, and o_frame_bad never asserts.

## Test plan
- Reset: hold i_rst 3 cycles with line toggling -> all outputs at reset values, o_otn_tx_ack=1, no strobes.
- Good frame, FRAME_BYTES=16, i_arq_en=1: serialize F6 F6 F6 28 28 28, payload 01..09, checksum 01^..^09=0x01 -> one fas pulse, 10 valid strobes with bytes 01..09,01, o_frame_good, line sequence 0,1,0 then 1.
- Bad checksum: same frame with last byte 0x55 -> o_frame_bad, line sequence 0,0,0 then 1; a following corrected frame is re-locked and returns good.
- FAS hunt: 13 random bits, then the frame -> lock only at the FAS end. A payload containing F6F6F6 does not relock mid-frame.
- i_arq_en=0 on a good frame -> o_frame_good pulses, o_otn_tx_ack stays 1 throughout.
- Reset asserted at payload byte 5 -> no good/bad pulse, next full frame received correctly.

Source files
------------

// File: rtl/otn_frame_rx_if.sv
// otn_frame_rx_if: byte stream and frame verdict bus from the OTN frame receiver to the demapper.
interface otn_frame_rx_if;
    logic [7:0] o_frame_data;
    logic       o_frame_data_valid;
    logic       o_frame_data_fas;
    logic       o_frame_good;
    logic       o_frame_bad;

    modport master (
        output o_frame_data,
        output o_frame_data_valid,
        output o_frame_data_fas,
        output o_frame_good,
        output o_frame_bad
    );

    modport slave (
        input o_frame_data,
        input o_frame_data_valid,
        input o_frame_data_fas,
        input o_frame_good,
        input o_frame_bad
    );
endinterface

// File: rtl/otn_frame_rx.sv
// otn_frame_rx: serial OTN frame receiver; bit recovery, FAS hunt, byte deserializer, checksum verdict and ACK return (checksum enabled by OTN_RX_CHECKSUM_EN).
module otn_frame_rx #(
    parameter int          FRAME_BYTES = 4165,
    parameter logic [47:0] FAS_PATTERN = 48'hF6F6F6282828
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk_en_16_x_baud,
    input  logic             i_otn_rx_data,
    input  logic             i_arq_en,
    output logic             o_otn_tx_ack,
    otn_frame_rx_if.master   frame_if
);
    localparam logic [12:0] LAST_IDX = 13'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {HUNT, RECEIVE, CHECK, ACK_START, ACK_BIT, ACK_STOP} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_meta_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_prev_q, rx_prev_d;
    logic [3:0]  phase_q, phase_d;
    logic [47:0] sr_q, sr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [12:0] byte_idx_q, byte_idx_d;
    logic        ack_q, ack_d;
    logic        last_q, last_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        fas_q, fas_d;
    logic        good_q, good_d;
    logic        bad_q, bad_d;
    logic        tx_ack_q, tx_ack_d;
`ifdef OTN_RX_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        line_edge;
    logic        bit_stb;
    logic        ack_v;
    logic [47:0] sr_shift;
    logic [47:0] fas_view;

    assign line_edge = rx_s_q ^ rx_prev_q;
    assign bit_stb   = i_sclk_en_16_x_baud && (phase_q == 4'd7) && !line_edge;
    assign sr_shift  = {rx_s_q, sr_q[47:1]};

    // Byte-order view of the shift register: oldest received byte lands in [47:40], matching FAS_PATTERN layout
    always_comb begin
        fas_view = '0;
        for (int k = 0; k < 6; k++) fas_view[47-8*k -: 8] = sr_shift[8*k+7 -: 8];
    end

    // Next-state logic: synchronizer, phase recovery, frame FSM and registered outputs
    always_comb begin
        rx_meta_d  = i_otn_rx_data;
        rx_s_d     = rx_meta_q;
        rx_prev_d  = rx_s_q;
        phase_d    = line_edge ? 4'd0 : i_sclk_en_16_x_baud ? phase_q + 4'd1 : phase_q;
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        ack_d      = ack_q;
        last_d     = 1'b0;
        data_d     = data_q;
        valid_d    = 1'b0;
        fas_d      = 1'b0;
        good_d     = 1'b0;
        bad_d      = 1'b0;
        tx_ack_d   = 1'b1;
`ifdef OTN_RX_CHECKSUM_EN
        csum_d     = csum_q;
        ack_v      = (data_q == csum_q);
`else
        ack_v      = 1'b1;
`endif
        case (state_q)
            HUNT: begin
                if (bit_stb) begin
                    sr_d = sr_shift;
                    if (fas_view == FAS_PATTERN) begin
                        fas_d      = 1'b1;
                        byte_idx_d = 13'd6;
                        bit_cnt_d  = 3'd0;
                        sr_d       = '0;
                        state_d    = RECEIVE;
`ifdef OTN_RX_CHECKSUM_EN
                        csum_d     = 8'd0;
`endif
                    end
                end
            end
            RECEIVE: begin
                if (bit_stb) begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_d  = sr_shift[47:40];
                        valid_d = 1'b1;
                        last_d  = (byte_idx_q == LAST_IDX);
                        if (byte_idx_q != LAST_IDX) begin
                            byte_idx_d = byte_idx_q + 13'd1;
`ifdef OTN_RX_CHECKSUM_EN
                            csum_d     = csum_q ^ sr_shift[47:40];
`endif
                        end
                    end
                end else if (last_q) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                ack_d    = ack_v;
                good_d   = ack_v;
                bad_d    = !ack_v;
                tx_ack_d = !i_arq_en;
                state_d  = i_arq_en ? ACK_START : HUNT;
            end
            ACK_START: begin
                tx_ack_d = ack_q;
                state_d  = ACK_BIT;
            end
            ACK_BIT: begin
                tx_ack_d = 1'b0;
                state_d  = ACK_STOP;
            end
            ACK_STOP: state_d = HUNT;
            default:  state_d = HUNT;
        endcase
        if (state_d == HUNT && state_q != HUNT) sr_d = '0;
    end

    // State and output registers with synchronous reset; line resets to idle high
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= HUNT;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            phase_q    <= 4'd0;
            sr_q       <= '0;
            bit_cnt_q  <= 3'd0;
            byte_idx_q <= 13'd0;
            ack_q      <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= 8'd0;
            valid_q    <= 1'b0;
            fas_q      <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
            tx_ack_q   <= 1'b1;
`ifdef OTN_RX_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            rx_meta_q  <= rx_meta_d;
            rx_s_q     <= rx_s_d;
            rx_prev_q  <= rx_prev_d;
            phase_q    <= phase_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            ack_q      <= ack_d;
            last_q     <= last_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            fas_q      <= fas_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            tx_ack_q   <= tx_ack_d;
`ifdef OTN_RX_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign frame_if.o_frame_data       = data_q;
    assign frame_if.o_frame_data_valid = valid_q;
    assign frame_if.o_frame_data_fas   = fas_q;
    assign frame_if.o_frame_good       = good_q;
    assign frame_if.o_frame_bad        = bad_q;
    assign o_otn_tx_ack                = tx_ack_q;
endmodule

// File: tb/tb_otn_frame_rx.sv
// tb_otn_frame_rx: scoreboard bench for otn_frame_rx with 16-byte frames and directed serial stimulus.
module tb_otn_frame_rx;
    localparam int FB = 16;
    localparam int K_FAS = 0, K_DATA = 1, K_GOOD = 2, K_BAD = 3;
`ifdef OTN_RX_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic [3:0] seq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic rx  = 1'b1;
    logic arq = 1'b1;
    logic tx_ack;

    exp_t q[$];
    int n_cmp = 0;
    int n_err = 0;
    int ack_win = 0;
    logic [3:0] ack_exp, ack_got;

    otn_frame_rx_if fif ();

    otn_frame_rx #(.FRAME_BYTES(FB), .FAS_PATTERN(48'hF6F6F6282828)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_sclk_en_16_x_baud (en),
        .i_otn_rx_data       (rx),
        .i_arq_en            (arq),
        .o_otn_tx_ack        (tx_ack),
        .frame_if            (fif.master)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        en = ~en;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d events still expected", q.size());
        $fatal(1, "watchdog");
    end

    task automatic push(input int kind, input logic [7:0] d, input logic [3:0] s);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.seq  = s;
        q.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %02h, expected %02h", nm, got, want);
        end
    endtask

    task automatic chk_ev(input string nm, input int kind, input logic [7:0] d, output logic [3:0] s);
        exp_t e;
        s = 4'b1111;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected event kind %0d data %02h, nothing expected", nm, kind, d);
        end else begin
            e = q.pop_front();
            s = e.seq;
            if (e.kind != kind || e.data !== d) begin
                n_err++;
                $display("FAIL %s: got kind %0d data %02h, expected kind %0d data %02h", nm, kind, d, e.kind, e.data);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every DUT event and tracks the ACK line
    always @(negedge clk) begin
        logic [3:0] s;
        if (rst) begin
            ack_win = 0;
        end else begin
            if (fif.o_frame_data_fas) chk_ev("fas", K_FAS, 8'h00, s);
            if (fif.o_frame_data_valid) chk_ev("data", K_DATA, fif.o_frame_data, s);
            if (fif.o_frame_good || fif.o_frame_bad) begin
                chk_ev("verdict", fif.o_frame_good ? K_GOOD : K_BAD, 8'h00, s);
                ack_exp = s;
                ack_got = 4'b0000;
                ack_win = 4;
            end
            if (ack_win > 0) begin
                ack_got = {ack_got[2:0], tx_ack};
                ack_win--;
                if (ack_win == 0) begin
                    n_cmp++;
                    if (ack_got !== ack_exp) begin
                        n_err++;
                        $display("FAIL ack_seq: got %b, expected %b", ack_got, ack_exp);
                    end
                end
            end else begin
                n_cmp++;
                if (tx_ack !== 1'b1) begin
                    n_err++;
                    $display("FAIL ack_idle: got %b, expected 1", tx_ack);
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (32) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_fas();
        send_byte(8'hF6); send_byte(8'hF6); send_byte(8'hF6);
        send_byte(8'h28); send_byte(8'h28); send_byte(8'h28);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic run_frame(input logic [7:0] pl [9], input logic [7:0] ck);
        logic [7:0] x;
        logic g;
        x = 8'h00;
        push(K_FAS, 8'h00, 4'b1111);
        for (int i = 0; i < 9; i++) begin
            push(K_DATA, pl[i], 4'b1111);
            x = x ^ pl[i];
        end
        push(K_DATA, ck, 4'b1111);
        g = !CS_EN || (ck == x);
        push(g ? K_GOOD : K_BAD, 8'h00, arq ? {1'b0, g, 1'b0, 1'b1} : 4'b1111);
        send_fas();
        for (int i = 0; i < 9; i++) send_byte(pl[i]);
        send_byte(ck);
        idle(4);
    endtask

    initial begin
        logic [7:0] pl_a [9];
        logic [7:0] pl_h [9];
        logic [12:0] pre;
        pl_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        pl_h = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28, 8'h0A, 8'h0B, 8'h0C};
        pre  = 13'b1011001110100;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rx = ~rx;
        end
        cmp("rst_data", fif.o_frame_data, 8'h00);
        cmp("rst_valid", {7'd0, fif.o_frame_data_valid}, 8'h00);
        cmp("rst_fas", {7'd0, fif.o_frame_data_fas}, 8'h00);
        cmp("rst_good", {7'd0, fif.o_frame_good}, 8'h00);
        cmp("rst_bad", {7'd0, fif.o_frame_bad}, 8'h00);
        cmp("rst_ack", {7'd0, tx_ack}, 8'h01);
        rx  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        cmp("post_rst_ack", {7'd0, tx_ack}, 8'h01);
        cmp("post_rst_valid", {7'd0, fif.o_frame_data_valid}, 8'h00);
        idle(4);
        arq = 1'b1;
        run_frame(pl_a, 8'h01);
        run_frame(pl_a, 8'h55);
        run_frame(pl_a, 8'h01);
        for (int i = 0; i < 13; i++) send_bit(pre[i]);
        run_frame(pl_h, 8'hD3);
        arq = 1'b0;
        run_frame(pl_a, 8'h01);
        arq = 1'b1;
        push(K_FAS, 8'h00, 4'b1111);
        for (int i = 0; i < 4; i++) push(K_DATA, pl_a[i], 4'b1111);
        send_fas();
        for (int i = 0; i < 4; i++) send_byte(pl_a[i]);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        cmp("abort_ack", {7'd0, tx_ack}, 8'h01);
        idle(4);
        run_frame(pl_a, 8'h01);
        for (int i = 0; i < 2000 && (q.size() != 0 || ack_win != 0); i++) @(negedge clk);
        n_cmp++;
        if (q.size() != 0 || ack_win != 0) begin
            n_err++;
            $display("FAIL drain: got %0d events outstanding, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
